// File: rtl/flag_cond_unit_if.sv
// Bundles the ALU flag-capture inputs and condition query/response signals of flag_cond_unit.
// master = ALU/control side, slave = flag_cond_unit.
interface flag_cond_unit_if #(
  parameter int n = 4
);
  logic         flags_we;
  logic [3:0]   banderas;
  logic [n-1:0] result;
  logic         cond_valid;
  logic [3:0]   cond;
  logic         cond_ready;
  logic         pass_valid;
  logic         pass;
  logic [3:0]   flags_q;
  logic [n-1:0] result_q;
  logic [7:0]   v_count;

  modport master (
    output flags_we, banderas, result, cond_valid, cond,
    input  cond_ready, pass_valid, pass, flags_q, result_q, v_count
  );

  modport slave (
    input  flags_we, banderas, result, cond_valid, cond,
    output cond_ready, pass_valid, pass, flags_q, result_q, v_count
  );
endinterface

// File: rtl/flag_cond_unit.sv
// Flag register plus registered condition-code evaluator with a saturating overflow counter.
// Define FLAG_BYPASS_EN to forward incoming banderas to a query that coincides with a flag write.
module flag_cond_unit #(
  parameter int n = 4
) (
  input logic            clk,
  input logic            rst,
  flag_cond_unit_if.slave fc
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   held_cond_q, held_cond_d;
  logic [3:0]   flags_q, flags_d;
  logic [n-1:0] result_q, result_d;
  logic [7:0]   v_count_q, v_count_d;
  logic         pass_valid_q, pass_valid_d;
  logic         pass_q, pass_d;
  logic         cond_ready;
  logic         accept;

  // Flag order is {N,Z,C,V}; code 4'hF is reserved and never passes.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic flag_n, flag_z, flag_c, flag_v;
    logic res;
    {flag_n, flag_z, flag_c, flag_v} = f;
    case (code)
      4'h0:    res = flag_z;
      4'h1:    res = !flag_z;
      4'h2:    res = flag_c;
      4'h3:    res = !flag_c;
      4'h4:    res = flag_n;
      4'h5:    res = !flag_n;
      4'h6:    res = flag_v;
      4'h7:    res = !flag_v;
      4'h8:    res = flag_c && !flag_z;
      4'h9:    res = !flag_c || flag_z;
      4'hA:    res = (flag_n == flag_v);
      4'hB:    res = (flag_n != flag_v);
      4'hC:    res = !flag_z && (flag_n == flag_v);
      4'hD:    res = flag_z || (flag_n != flag_v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    held_cond_d  = held_cond_q;
    pass_valid_d = 1'b0;
    pass_d       = pass_q;
    cond_ready   = (state_q == IDLE);
    accept       = fc.cond_valid && cond_ready;

    flags_d   = flags_q;
    result_d  = result_q;
    v_count_d = v_count_q;
    if (fc.flags_we) begin
      flags_d  = fc.banderas;
      result_d = fc.result;
      if (fc.banderas[0] && (v_count_q != 8'hFF)) v_count_d = v_count_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FLAG_BYPASS_EN
          pass_valid_d = 1'b1;
          pass_d       = cond_eval(fc.cond, fc.flags_we ? fc.banderas : flags_q);
`else
          // A query racing a flag write waits one cycle so it sees the new flags_q.
          if (fc.flags_we) begin
            held_cond_d = fc.cond;
            state_d     = HOLD;
          end else begin
            pass_valid_d = 1'b1;
            pass_d       = cond_eval(fc.cond, flags_q);
          end
`endif
        end
      end
      HOLD: begin
        pass_valid_d = 1'b1;
        pass_d       = cond_eval(held_cond_q, flags_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      held_cond_q  <= 4'h0;
      flags_q      <= 4'h0;
      result_q     <= '0;
      v_count_q    <= 8'h00;
      pass_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_cond_q  <= held_cond_d;
      flags_q      <= flags_d;
      result_q     <= result_d;
      v_count_q    <= v_count_d;
      pass_valid_q <= pass_valid_d;
      pass_q       <= pass_d;
    end
  end

  assign fc.cond_ready = cond_ready;
  assign fc.pass_valid = pass_valid_q;
  assign fc.pass       = pass_q;
  assign fc.flags_q    = flags_q;
  assign fc.result_q   = result_q;
  assign fc.v_count    = v_count_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed scenarios plus randomized traffic
// compared against a behavioural model built from the condition-code rules.
module tb_flag_cond_unit;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  flag_cond_unit_if #(.n(N)) fc ();

  flag_cond_unit #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .fc  (fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [3:0]   m_flags;
  logic [N-1:0] m_result;
  int           m_vcount;
  logic         m_pass;

  typedef struct {
    int   due;
    logic val;
  } exp_t;
  exp_t exp_q[$];

  // Condition pairs share a base predicate; odd codes are its complement.
  function automatic logic ref_eval(input logic [3:0] code, input logic [3:0] f);
    bit nf, zf, cf, vf, base;
    nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
    case (code / 2)
      0: base = zf;
      1: base = cf;
      2: base = nf;
      3: base = vf;
      4: base = cf & ~zf;
      5: base = (nf == vf);
      6: base = ~zf & (nf == vf);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    fc.flags_we   = 1'b0;
    fc.banderas   = 4'h0;
    fc.result     = '0;
    fc.cond_valid = 1'b0;
    fc.cond       = 4'h0;
  endtask

  task automatic model_capture(input logic [3:0] b, input logic [N-1:0] r);
    m_flags  = b;
    m_result = r;
    if (b[0] && m_vcount < 255) m_vcount++;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    m_flags = 4'h0; m_result = '0; m_vcount = 0; m_pass = 1'b0;
    exp_q.delete();
  endtask

  task automatic capture(input logic [3:0] b, input logic [N-1:0] r);
    fc.flags_we = 1'b1; fc.banderas = b; fc.result = r;
    step();
    fc.flags_we = 1'b0;
    model_capture(b, r);
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (fc.flags_q !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h want=0", fc.flags_q); end
    if (fc.result_q !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", fc.result_q); end
    if (fc.v_count !== 8'd0) begin bad++; $display("FAIL reset_vcount got=%0d want=0", fc.v_count); end
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b want=0", fc.pass_valid); end
    if (fc.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", fc.pass); end
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", fc.cond_ready); end
  endtask

  task automatic test_eq_ne_back_to_back();
    capture(4'b0100, 4'h0);
    fc.cond_valid = 1'b1; fc.cond = 4'h0;
    step();
    total += 2;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL eq_pv got=%b want=1", fc.pass_valid); end
    if (fc.pass !== 1'b1) begin bad++; $display("FAIL eq_pass got=%b want=1", fc.pass); end
    fc.cond = 4'h1;
    step();
    total += 2;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL ne_pv got=%b want=1", fc.pass_valid); end
    if (fc.pass !== 1'b0) begin bad++; $display("FAIL ne_pass got=%b want=0", fc.pass); end
    fc.cond_valid = 1'b0;
    step();
    total += 2;
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL idle_pv got=%b want=0", fc.pass_valid); end
    if (fc.pass !== 1'b0) begin bad++; $display("FAIL hold_pass got=%b want=0", fc.pass); end
  endtask

  task automatic test_signed_conds();
    logic [3:0] codes[6];
    logic       want[6];
    codes = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    want  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    capture(4'b1000, 4'h5);
    for (int i = 0; i < 6; i++) begin
      fc.cond_valid = 1'b1; fc.cond = codes[i];
      step();
      total += 2;
      if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL signed_pv code=%h got=%b want=1", codes[i], fc.pass_valid); end
      if (fc.pass !== want[i]) begin bad++; $display("FAIL signed_pass code=%h got=%b want=%b", codes[i], fc.pass, want[i]); end
    end
    fc.cond_valid = 1'b0;
    step();
  endtask

  task automatic test_simul_write();
    capture(4'b0000, 4'h0);
    fc.flags_we = 1'b1; fc.banderas = 4'b0010; fc.result = 4'h3;
    fc.cond_valid = 1'b1; fc.cond = 4'h2;
    total++;
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL simul_ready_pre got=%b want=1", fc.cond_ready); end
    step();
    idle_inputs();
    model_capture(4'b0010, 4'h3);
`ifdef FLAG_BYPASS_EN
    total += 3;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL simul_pv got=%b want=1", fc.pass_valid); end
    if (fc.pass !== 1'b1) begin bad++; $display("FAIL simul_pass got=%b want=1", fc.pass); end
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b want=1", fc.cond_ready); end
    step();
`else
    total += 2;
    if (fc.cond_ready !== 1'b0) begin bad++; $display("FAIL simul_hold_ready got=%b want=0", fc.cond_ready); end
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL simul_hold_pv got=%b want=0", fc.pass_valid); end
    step();
    total += 3;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL simul_pv got=%b want=1", fc.pass_valid); end
    if (fc.pass !== 1'b1) begin bad++; $display("FAIL simul_pass got=%b want=1", fc.pass); end
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b want=1", fc.cond_ready); end
`endif
    step();
    total++;
    if (fc.flags_q !== 4'b0010) begin bad++; $display("FAIL simul_flags got=%b want=0010", fc.flags_q); end
  endtask

  task automatic test_v_saturation();
    logic [3:0] b;
    logic [N-1:0] r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      b = 4'($urandom) | 4'b0001;
      r = N'($urandom);
      capture(b, r);
      total++;
      if (fc.v_count !== 8'(m_vcount)) begin bad++; $display("FAIL vsat_count i=%0d got=%0d want=%0d", i, fc.v_count, m_vcount); end
    end
    capture(4'b1110, 4'h9);
    total += 3;
    if (fc.v_count !== 8'd255) begin bad++; $display("FAIL vsat_v0 got=%0d want=255", fc.v_count); end
    if (fc.flags_q !== 4'b1110) begin bad++; $display("FAIL vsat_flags got=%b want=1110", fc.flags_q); end
    if (fc.result_q !== 4'h9) begin bad++; $display("FAIL vsat_result got=%h want=9", fc.result_q); end
  endtask

  task automatic test_reset_in_hold();
    capture(4'b1011, 4'h7);
    fc.flags_we = 1'b1; fc.banderas = 4'b0100; fc.result = 4'h2;
    fc.cond_valid = 1'b1; fc.cond = 4'h0;
`ifdef FLAG_BYPASS_EN
    rst = 1'b1;
    step();
`else
    step();
    idle_inputs();
    total++;
    if (fc.cond_ready !== 1'b0) begin bad++; $display("FAIL rsthold_enter got=%b want=0", fc.cond_ready); end
    rst = 1'b1;
    step();
`endif
    idle_inputs();
    total += 6;
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL rsthold_pv got=%b want=0", fc.pass_valid); end
    if (fc.pass !== 1'b0) begin bad++; $display("FAIL rsthold_pass got=%b want=0", fc.pass); end
    if (fc.flags_q !== 4'h0) begin bad++; $display("FAIL rsthold_flags got=%b want=0", fc.flags_q); end
    if (fc.result_q !== '0) begin bad++; $display("FAIL rsthold_result got=%h want=0", fc.result_q); end
    if (fc.v_count !== 8'd0) begin bad++; $display("FAIL rsthold_vcount got=%0d want=0", fc.v_count); end
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL rsthold_ready got=%b want=1", fc.cond_ready); end
    rst = 1'b0;
    step();
    total += 2;
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL rsthold_pv2 got=%b want=0", fc.pass_valid); end
    if (fc.cond_ready !== 1'b1) begin bad++; $display("FAIL rsthold_ready2 got=%b want=1", fc.cond_ready); end
    m_flags = 4'h0; m_result = '0; m_vcount = 0; m_pass = 1'b0;
  endtask

  task automatic test_write_during_hold();
    fc.flags_we = 1'b1; fc.banderas = 4'b0100; fc.result = 4'h1;
    fc.cond_valid = 1'b1; fc.cond = 4'h0;
    step();
    fc.cond_valid = 1'b0;
    fc.flags_we = 1'b1; fc.banderas = 4'b0000; fc.result = 4'h0;
`ifdef FLAG_BYPASS_EN
    total += 2;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL wdh_pv got=%b want=1", fc.pass_valid); end
    if (fc.pass !== 1'b1) begin bad++; $display("FAIL wdh_pass got=%b want=1", fc.pass); end
    step();
    total += 2;
    if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL wdh_pv2 got=%b want=0", fc.pass_valid); end
`else
    total += 2;
    if (fc.flags_q !== 4'b0100) begin bad++; $display("FAIL wdh_flags1 got=%b want=0100", fc.flags_q); end
    if (fc.cond_ready !== 1'b0) begin bad++; $display("FAIL wdh_ready got=%b want=0", fc.cond_ready); end
    step();
    total += 2;
    if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL wdh_pv got=%b want=1", fc.pass_valid); end
`endif
    if (fc.pass !== 1'b1) begin bad++; $display("FAIL wdh_pass2 got=%b want=1", fc.pass); end
    idle_inputs();
    total++;
    if (fc.flags_q !== 4'b0000) begin bad++; $display("FAIL wdh_flags got=%b want=0000", fc.flags_q); end
    step();
  endtask

  task automatic test_random();
    logic       acc;
    logic       exp_ready;
    int         hold_cyc;
    int         lat;
    exp_t       e;
    do_reset();
    hold_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      fc.flags_we   = ($urandom_range(0, 2) == 0);
      fc.banderas   = 4'($urandom);
      fc.result     = N'($urandom);
      fc.cond_valid = $urandom_range(0, 1) == 1;
      fc.cond       = 4'($urandom);
      exp_ready = (cyc != hold_cyc);
      total++;
      if (fc.cond_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready i=%0d got=%b want=%b", i, fc.cond_ready, exp_ready); end
      acc = fc.cond_valid && exp_ready;
      if (acc) begin
`ifdef FLAG_BYPASS_EN
        lat = 1;
`else
        lat = fc.flags_we ? 2 : 1;
`endif
        if (lat == 2) hold_cyc = cyc + 1;
        e.due = cyc + lat;
        e.val = ref_eval(fc.cond, fc.flags_we ? fc.banderas : m_flags);
        exp_q.push_back(e);
      end
      if (fc.flags_we) model_capture(fc.banderas, fc.result);
      step();
      total += 5;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_pass = exp_q[0].val;
        exp_q.pop_front();
        if (fc.pass_valid !== 1'b1) begin bad++; $display("FAIL rnd_pv i=%0d got=%b want=1", i, fc.pass_valid); end
      end else begin
        if (fc.pass_valid !== 1'b0) begin bad++; $display("FAIL rnd_pv i=%0d got=%b want=0", i, fc.pass_valid); end
      end
      if (fc.pass !== m_pass) begin bad++; $display("FAIL rnd_pass i=%0d got=%b want=%b", i, fc.pass, m_pass); end
      if (fc.flags_q !== m_flags) begin bad++; $display("FAIL rnd_flags i=%0d got=%b want=%b", i, fc.flags_q, m_flags); end
      if (fc.result_q !== m_result) begin bad++; $display("FAIL rnd_result i=%0d got=%h want=%h", i, fc.result_q, m_result); end
      if (fc.v_count !== 8'(m_vcount)) begin bad++; $display("FAIL rnd_vcount i=%0d got=%0d want=%0d", i, fc.v_count, m_vcount); end
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_eq_ne_back_to_back();
    test_signed_conds();
    test_simul_write();
    test_v_saturation();
    test_reset_in_hold();
    test_write_during_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
# flag_cond_unit

Flag register and condition evaluator on the consumer side of the ALU status flags. Captures the 4-bit {N,Z,C,V} `banderas` vector and the result of whichever ALU unit executed, holds them, and answers condition-code queries from the control path with a registered pass/fail. Also keeps a saturating count of overflow events for debug. Sits between the ALU flag outputs and the branch/conditional-execute logic.

## Interface

- `n`, default 4: width of the ALU result captured alongside the flags.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flags_we` in 1: capture `banderas` and `result` this cycle.
- `banderas` in 4: [3]=N, [2]=Z, [1]=C, [0]=V from the ALU.
- `result` in n: ALU result accompanying `banderas`.
- `cond_valid` in 1: condition query present.
- `cond` in 4: condition code (encoding below).
- `cond_ready` out 1: query accepted when `cond_valid && cond_ready`.
- `pass_valid` out 1: one-cycle pulse, `pass` is valid.
- `pass` out 1: condition outcome.
- `flags_q` out 4: registered {N,Z,C,V}.
- `result_q` out n: registered result.
- `v_count` out 8: saturating count of captures with V=1.

## Operation

- Capture: on `flags_we`, `flags_q <= banderas`, `result_q <= result`. If `banderas[0]` is set and `v_count != 255`, `v_count` increments; it holds at 255.
- Condition encoding (F = flags used for evaluation):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F NV: 0 (reserved, always fails).
- FSM states: IDLE, HOLD.
  - IDLE: `cond_ready`=1. Accepted query without a simultaneous `flags_we` is evaluated against `flags_q`. The next cycle has `pass_valid`=1; stay in IDLE.
  - IDLE with accepted query and simultaneous `flags_we`: handling is set by Configuration.
  - HOLD: `cond_ready`=0. The held code is evaluated against `flags_q`, which already holds the flags written on entry. The next cycle has `pass_valid`=1; return to IDLE.
  - A `flags_we` during HOLD still captures. The held evaluation uses the pre-edge `flags_q`, not the new `banderas`.
- `pass` holds its last value when `pass_valid`=0.

## Timing

- Reset values: `flags_q`=0, `result_q`=0, `v_count`=0, `pass_valid`=0, `pass`=0, FSM=IDLE, `cond_ready`=1 in the cycle after reset.
- `rst` overrides all activity. A query in HOLD at reset is dropped, with no `pass_valid`.
- Latency, accept edge to `pass_valid`:
  - Normal query: 1 cycle.
  - Query with simultaneous flag write in the non-bypass build: 2 cycles.
- Throughput: one query per cycle in IDLE, back to back.
- `flags_q`, `result_q` and `v_count` update on the edge after `flags_we`.

## Configuration

- `FLAG_BYPASS_EN` defined:
  - A query accepted in the same cycle as `flags_we` is evaluated against incoming `banderas` (forwarded).
  - Latency is 1 cycle and HOLD is never entered.
- Not defined:
  - That query is registered, the FSM enters HOLD and the query is evaluated the next cycle against the newly written `flags_q`.
  - `cond_ready` is low during HOLD.
- Flag capture and `v_count` behaviour are identical in both builds.

## Test plan

- Reset, then capture `banderas`=4'b0100, `result`=0. Query EQ, then NE, back to back -> `pass` is 1, then 0, on consecutive cycles. Each has `pass_valid`=1 one cycle after accept.
- `flags_q`=4'b1000 (N=1,V=0): query GE, LT, GT, LE, AL, NV -> 0,1,0,1,1,0.
- `flags_q`=0. Same cycle: `flags_we` with `banderas`=4'b0010 and query CS.
  - Bypass build: `pass`=1 after 1 cycle, `cond_ready` stays 1.
  - Non-bypass build: `cond_ready`=0 for one cycle, then `pass`=1 two cycles after accept.
- 300 captures with V=1 -> `v_count` reaches 255 and holds. A capture with V=0 leaves it at 255.
- Non-bypass build: enter HOLD, assert `rst` in the HOLD cycle -> no `pass_valid`, all outputs at reset values, `cond_ready`=1 the next cycle.
- `flags_we` during HOLD with `banderas`=4'b0000, held query EQ after writing 4'b0100 -> `pass`=1, and `flags_q`=0 afterwards.
